// File: rtl/ps2_pkg.sv
// Shared constants, deframer state type and frame check helper for the PS/2 receiver.
package ps2_pkg;

    localparam int   PS2_FRAME_BITS = 11;
    localparam logic PS2_START      = 1'b0;
    localparam logic PS2_STOP       = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } ps2_state_t;

    // A frame is good when data+parity carry odd parity and the stop bit is high.
    function automatic logic frame_ok(input logic [8:0] data_par, input logic stop_bit);
        return (^data_par) & (stop_bit == PS2_STOP);
    endfunction

endpackage

// File: rtl/ps2_rx_if.sv
// Downstream read handshake and status of the PS/2 receiver.
interface ps2_rx_if;

    logic       rd_en;
    logic [7:0] data;
    logic       valid;
    logic       overflow;
    logic       frame_err;

    modport master (input rd_en, output data, output valid, output overflow, output frame_err);
    modport slave  (output rd_en, input data, input valid, input overflow, input frame_err);

endinterface

// File: rtl/ps2_fifo.sv
// Synchronous show-ahead FIFO; a read on a full FIFO lets a same-cycle write in.
module ps2_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic             rd_acc_s;
    logic             wr_acc_s;

    assign empty    = (wr_ptr_r == rd_ptr_r);
    assign full     = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign rd_acc_s = rd_en & ~empty;
    assign wr_acc_s = wr_en & (~full | rd_acc_s);
    assign rd_data  = mem_r[rd_ptr_r[AW-1:0]];

    // Pointer and storage update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (wr_acc_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
                wr_ptr_r                <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (rd_acc_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: pin synchronisers, 11-bit deframer with idle
// timeout, and a show-ahead scan-code FIFO.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     ps2_clk,
    input  logic     ps2_data,
    ps2_rx_if.master bus
);

    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

    logic [2:0]  clk_sync_r;
    logic [1:0]  data_sync_r;
    logic        fall_s;
    logic        bit_s;

    ps2_state_t  state_r, state_next_s;
    logic [3:0]  cnt_r, cnt_next_s;
    logic [8:0]  shift_r, shift_next_s;
    logic [IW-1:0] idle_r;
    logic        good_s;
    logic        err_s;

    logic        frame_err_r;
    logic        overflow_r;
    logic        full_s;
    logic        empty_s;
    logic        rd_acc_s;
    logic        drop_s;
    logic [7:0]  fifo_data_s;

    assign fall_s = clk_sync_r[2] & ~clk_sync_r[1];
    assign bit_s  = data_sync_r[1];

    // Pin synchronisers; reset to the idle bus level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync_r  <= 3'b111;
            data_sync_r <= 2'b11;
        end else begin
            clk_sync_r  <= {clk_sync_r[1:0], ps2_clk};
            data_sync_r <= {data_sync_r[0], ps2_data};
        end
    end

    // Idle counter: cleared on each falling PS/2 edge, saturates at the timeout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_r <= '0;
        end else if (fall_s) begin
            idle_r <= '0;
        end else if (idle_r != IW'(TIMEOUT_CYCLES)) begin
            idle_r <= idle_r + {{(IW-1){1'b0}}, 1'b1};
        end else begin
            idle_r <= idle_r;
        end
    end

    // Deframer state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
            shift_r <= 9'd0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            shift_r <= shift_next_s;
        end
    end

    // Deframer next state: shift bits 1..9 LSB-first, judge the frame on the stop bit.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        shift_next_s = shift_r;
        good_s       = 1'b0;
        err_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (fall_s && (bit_s == PS2_START)) begin
                    state_next_s = RECV;
                    cnt_next_s   = 4'd1;
                end else begin
                    cnt_next_s   = 4'd0;
                end
            end
            RECV: begin
                if (fall_s) begin
                    if (cnt_r == 4'(PS2_FRAME_BITS - 1)) begin
                        state_next_s = IDLE;
                        cnt_next_s   = 4'd0;
                        if (frame_ok(shift_r, bit_s)) begin
                            good_s = 1'b1;
                        end else begin
                            err_s  = 1'b1;
                        end
                    end else begin
                        shift_next_s = {bit_s, shift_r[8:1]};
                        cnt_next_s   = cnt_r + 4'd1;
                    end
                end else if (idle_r == IW'(TIMEOUT_CYCLES)) begin
                    state_next_s = IDLE;
                    cnt_next_s   = 4'd0;
                    err_s        = 1'b1;
                end else begin
                    state_next_s = RECV;
                end
            end
            default: begin
                state_next_s = IDLE;
                cnt_next_s   = 4'd0;
            end
        endcase
    end

    assign rd_acc_s = bus.rd_en & ~empty_s;
    assign drop_s   = good_s & full_s & ~rd_acc_s;

    // Status flags; a drop outranks a clearing read in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_err_r <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            frame_err_r <= err_s;
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (rd_acc_s) begin
                overflow_r <= 1'b0;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

    ps2_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (good_s),
        .wr_data (shift_r[7:0]),
        .rd_en   (bus.rd_en),
        .rd_data (fifo_data_s),
        .full    (full_s),
        .empty   (empty_s)
    );

    assign bus.data      = fifo_data_s;
    assign bus.valid     = ~empty_s;
    assign bus.overflow  = overflow_r;
    assign bus.frame_err = frame_err_r;

endmodule
